// File: rtl/counter_4bit_if.sv
// counter_4bit_if: carries the count and terminal-count flag; master drives, slave observes.
//   WIDTH : count width in bits (must match the attached counter_4bit)
//   out   : current count
//   tc    : high while out equals the counter's terminal value
interface counter_4bit_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] out;
  logic             tc;
  modport master(output out, tc);
  modport slave(input out, tc);
endinterface

// File: rtl/counter_4bit.sv
// counter_4bit: free-running up-counter, terminal value MAX_COUNT, async active-low reset.
//   clk    : sole clock, rising edge
//   rst    : asynchronous reset, active low (0 clears the count)
//   cnt_if : master modport, out = count register, tc = (out == MAX_COUNT)
// Define COUNTER_SATURATE_EN to hold at MAX_COUNT instead of wrapping to 0.
module counter_4bit #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic           clk,
  input  logic           rst,
  counter_4bit_if.master cnt_if
);
  if (WIDTH < 2 || WIDTH > 16 || MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH-1) begin : g_bad_param
    $error("counter_4bit: illegal WIDTH or MAX_COUNT");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic at_max;
  assign at_max = cnt_q == MAX;
`ifdef COUNTER_SATURATE_EN
  assign cnt_d = at_max ? MAX : cnt_q + WIDTH'(1);
`else
  assign cnt_d = at_max ? '0 : cnt_q + WIDTH'(1);
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  assign cnt_if.out = cnt_q;
  assign cnt_if.tc  = at_max;
endmodule

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit: random reset/run stimulus on three counter configurations against an arithmetic model.
`timescale 1ns/1ps
module tb_counter_4bit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int errs = 0;
  int m0 = 0, m9 = 0, m20 = 0;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  always #5 clk = ~clk;

  counter_4bit_if #(.WIDTH(4)) if0();
  counter_4bit_if #(.WIDTH(4)) if9();
  counter_4bit_if #(.WIDTH(5)) if20();
  counter_4bit #(.WIDTH(4))                 u0 (.clk(clk), .rst(rst), .cnt_if(if0.master));
  counter_4bit #(.WIDTH(4), .MAX_COUNT(9))  u9 (.clk(clk), .rst(rst), .cnt_if(if9.master));
  counter_4bit #(.WIDTH(5), .MAX_COUNT(20)) u20(.clk(clk), .rst(rst), .cnt_if(if20.master));

  function automatic int nxt(int m, int mx);
    return SAT ? (m < mx ? m + 1 : mx) : (m + 1) % (mx + 1);
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m0 <= 0; m9 <= 0; m20 <= 0;
    end else begin
      m0 <= nxt(m0, 15); m9 <= nxt(m9, 9); m20 <= nxt(m20, 20);
    end

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("out_w4", int'(if0.out), m0);
    check("tc_w4", int'(if0.tc), int'(m0 == 15));
    check("out_m9", int'(if9.out), m9);
    check("tc_m9", int'(if9.tc), int'(m9 == 9));
    check("out_m20", int'(if20.out), m20);
    check("tc_m20", int'(if20.tc), int'(m20 == 20));
  end

  task automatic release_rst();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic edge_chk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("por_out", int'(if0.out), 0);
    check("por_tc", int'(if0.tc), 0);
    release_rst();
    for (int i = 1; i <= 3; i++) begin
      edge_chk();
      check("first_edges", int'(if0.out), i);
      check("first_tc", int'(if0.tc), 0);
    end
    repeat (12) edge_chk();
    check("reach15", int'(if0.out), 15);
    check("tc15", int'(if0.tc), 1);
    edge_chk();
    check("after15", int'(if0.out), SAT ? 15 : 0);
    check("tc_after15", int'(if0.tc), SAT ? 1 : 0);
    repeat (4) edge_chk();
    check("sat_hold", int'(if0.out), SAT ? 15 : 4);
    rst = 1'b0;
    #1;
    check("rst_out", int'(if0.out), 0);
    check("rst_tc", int'(if0.tc), 0);
    release_rst();
    repeat (6) edge_chk();
    check("at6", int'(if0.out), 6);
    #2 rst = 1'b0;
    #1;
    check("async_clr", int'(if0.out), 0);
    check("async_clr_m9", int'(if9.out), 0);
    release_rst();
    edge_chk();
    check("restart", int'(if0.out), 1);
    repeat (8) edge_chk();
    check("m9_top", int'(if9.out), 9);
    check("m9_tc", int'(if9.tc), 1);
    check("w4_at9_tc", int'(if0.tc), 0);
    edge_chk();
    check("m9_next", int'(if9.out), SAT ? 9 : 0);
    check("m9_next_tc", int'(if9.tc), SAT ? 1 : 0);
    for (int it = 0; it < 150; it++) begin
      repeat ($urandom_range(1, 40)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) begin
        #($urandom_range(1, 3));
        rst = 1'b0;
        #1;
        check("rand_clr", int'(if20.out), 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        release_rst();
      end
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
